mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares one single-port, variable-latency memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Accepts one request at a time and drives the memory handshake until completion or timeout.
- Returns a one-cycle response to the winning requester.
- Data accesses have priority over fetches, with a starvation guard for fetch.

Parameters:
- DATA_W, 32, address and data width.
- STARVE_MAX, 4, consecutive data wins while fetch is waiting before fetch is forced to win (1..15).
- TIMEOUT, 255, cycles of mem_req without mem_ready before abort; 0 disables timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; sampled only in IDLE.
- if_addr  in  DATA_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: fetch response valid.
- d_req  in  1  data request; sampled only in IDLE.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  DATA_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: data response valid.
- rsp_rdata  out  DATA_W  read data, valid with either rvalid.
- rsp_err  out  1  timeout flag, valid with either rvalid.
- mem_req  out  1  memory access in progress.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completion; sampled while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) sets:
  - state to IDLE;
  - starve_cnt and tmo_cnt to 0;
  - all gnt, rvalid, mem_req, mem_we, rsp_err to 0;
  - mem_addr, mem_wdata, rsp_rdata to 0.
- Reset mid-access aborts the access silently: no rvalid is issued afterwards.

States:
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise pick an owner:
    - only one requester: that requester wins;
    - both requesting: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - At the clock edge:
    - latch address, wdata and we (we forced 0 for fetch);
    - set the owner's gnt=1 and mem_req=1;
    - go to ACCESS.
- ACCESS:
  - gnt is high only in the first ACCESS cycle.
  - mem_req/mem_we/mem_addr/mem_wdata stay stable until mem_ready=1 is sampled.
  - On mem_ready=1:
    - mem_req drops;
    - owner's rvalid=1 next cycle;
    - rsp_rdata = mem_rdata for loads and fetches, 0 for stores;
    - rsp_err=0;
    - return to IDLE.
  - Timeout (TIMEOUT>0): tmo_cnt counts ACCESS cycles with mem_ready=0. When tmo_cnt reaches TIMEOUT:
    - mem_req drops;
    - rvalid=1, rsp_err=1, rsp_rdata=0;
    - return to IDLE.
  - mem_ready on the same cycle as the timeout: mem_ready wins and the access completes normally.
- Outside their pulse cycle, rvalid, rsp_err and rsp_rdata return to 0.

Requester rules:
- Hold req and operands stable until gnt is seen.
- Requests are not sampled in ACCESS.
- A req still high when the FSM returns to IDLE is treated as a new request.

Starvation counter (starve_cnt):
- +1 (saturating at STARVE_MAX) when both requesters are present and data wins.
- Cleared to 0 whenever fetch wins.
- Unchanged otherwise.

Latency and throughput:
- req in cycle 0 → gnt and mem_req in cycle 1.
- mem_ready in cycle 1 → rvalid in cycle 2, FSM back in IDLE in cycle 2.
- Next request sampled in cycle 2 → gnt in cycle 3.
- Maximum rate: one access per 2 cycles.

Decomposition:
- Shared package riscv_pkg holds:
  - arb_state_t enum {IDLE, ACCESS};
  - arb_owner_t enum {OWN_FETCH, OWN_DATA};
  - default constants ARB_STARVE_MAX and ARB_TIMEOUT.
- One natural sub-module: arb_pick, a combinational owner selection from if_req, d_req and starve_cnt==STARVE_MAX.
- Counters and the FSM stay in mem_port_arbiter.

Test Plan:
- Reset during ACCESS: d_req load to 0x100, mem_ready held 0, reset=0 on cycle 3 → all outputs 0 immediately; no d_rvalid after reset release; state IDLE.
- Single fetch: if_req, if_addr=0x40, mem_ready=1 on first mem_req cycle, mem_rdata=0x00500093 → if_gnt in cycle 1, if_rvalid in cycle 2 with rsp_rdata=0x00500093, rsp_err=0.
- Store with wait states: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ready after 3 cycles → mem_we=1 and mem_addr/mem_wdata stable for all 3 cycles; d_rvalid with rsp_rdata=0.
- Starvation guard (STARVE_MAX=4): if_req and d_req held high continuously, zero-wait memory → grant order D,D,D,D,F,D,D,D,D,F.
- Timeout (TIMEOUT=5): d_req load, mem_ready never asserted → mem_req high for exactly 5 cycles, then d_rvalid=1 with rsp_err=1 and rsp_rdata=0.
- Timeout/ready collision: mem_ready=1 in the same cycle tmo_cnt reaches TIMEOUT → rsp_err=0, rsp_rdata=mem_rdata.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared arbiter state/owner types and default tuning constants
package riscv_pkg;
    typedef enum logic {IDLE, ACCESS} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} arb_owner_t;
    localparam int ARB_STARVE_MAX = 4;
    localparam int ARB_TIMEOUT = 255;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational owner selection, data first unless fetch has starved
module arb_pick
    import riscv_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       starved,
    output logic       valid,
    output arb_owner_t owner
);
    assign valid = if_req | d_req;
    assign owner = (d_req && !(if_req && starved)) ? OWN_DATA : OWN_FETCH;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    parameter int TIMEOUT    = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TW = $clog2(TIMEOUT + 2);
    arb_state_t    state;
    arb_owner_t    owner;
    logic [3:0]    starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          pick_valid;
    arb_owner_t    pick_owner;
    logic          tmo_hit;
    arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .starved (starve_cnt == 4'(STARVE_MAX)),
        .valid   (pick_valid),
        .owner   (pick_owner)
    );
    // this cycle is the TIMEOUT-th without mem_ready; a same-cycle ready still wins
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (state == IDLE) begin
                if (pick_valid) begin
                    owner   <= pick_owner;
                    mem_req <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ACCESS;
                    if (pick_owner == OWN_DATA) begin
                        d_gnt     <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // data can only beat a waiting fetch below STARVE_MAX, so this saturates
                        if (if_req)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else begin
                        if_gnt     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
            end else if (mem_ready || tmo_hit) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                if_rvalid <= owner == OWN_FETCH;
                d_rvalid  <= owner == OWN_DATA;
                rsp_err   <= !mem_ready;
                rsp_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                state     <= IDLE;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random transactions checked against a transaction-level scoreboard
module tb_mem_port_arbiter;
    localparam int SMAX = 4;
    localparam int TMO  = 5;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [64];
    int          n_total = 0;
    int          n_pass = 0;
    int          sc = 0;
    bit          if_p = 0;
    bit          d_p = 0;
    bit          fw;
    mem_port_arbiter #(.DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask
    // one arbitrated access: lat = ACCESS cycles before mem_ready (>= TMO means never)
    task automatic txn(input bit new_if, input bit new_d, input int lat, output bit fetch_won);
        bit          f, we, err;
        int          idx;
        logic [31:0] a, wd, exp;
        if (new_if && !if_p) begin
            if_p = 1;
            if_addr = 32'($urandom_range(0, 63) * 4);
        end
        if ((new_d || (!if_p && !new_if)) && !d_p) begin
            d_p = 1;
            d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 63) * 4);
            d_wdata = $urandom;
        end
        if_req = if_p;
        d_req = d_p;
        f = if_p && (!d_p || sc == SMAX);
        if (f) sc = 0;
        else if (if_p && sc < SMAX) sc++;
        @(negedge clk);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, f});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, !f});
        a = f ? if_addr : d_addr;
        we = f ? 1'b0 : d_we;
        wd = d_wdata;
        idx = int'(a[7:2]);
        if (f) begin if_p = 0; if_req = 0; end
        else begin d_p = 0; d_req = 0; end
        for (int k = 0; ; k++) begin
            chk("mem_req", {31'd0, mem_req}, 32'd1);
            chk("mem_addr", mem_addr, a);
            chk("mem_we", {31'd0, mem_we}, {31'd0, we});
            if (!f) chk("mem_wdata", mem_wdata, wd);
            if (k > 0) chk("gnt_pulse", {30'd0, if_gnt, d_gnt}, 32'd0);
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? mem[idx] : $urandom;
            @(negedge clk);
            if (k == lat || k == TMO - 1) break;
        end
        mem_ready = 0;
        err = lat >= TMO;
        exp = (err || we) ? 32'd0 : mem[idx];
        if (!err && we) mem[idx] = wd;
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, f});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, !f});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
        chk("rsp_rdata", rsp_rdata, exp);
        chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
        fetch_won = f;
    endtask
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[16] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1;
        // reset in the middle of a stalled load
        d_req = 1; d_we = 0; d_addr = 32'h100;
        @(negedge clk);
        chk("rst_t_gnt", {31'd0, d_gnt}, 32'd1);
        chk("rst_t_addr", mem_addr, 32'h100);
        d_req = 0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("rst_t_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_t_addr0", mem_addr, 32'd0);
        chk("rst_t_we", {31'd0, mem_we}, 32'd0);
        chk("rst_t_outs", {28'd0, if_gnt, d_gnt, d_rvalid, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1;
        sc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_t_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            chk("rst_t_idle_req", {31'd0, mem_req}, 32'd0);
        end
        // single zero-wait fetch
        if_p = 1; if_addr = 32'h40;
        txn(0, 0, 0, fw);
        chk("fetch_won", {31'd0, fw}, 32'd1);
        // both requesters held continuously
        for (int i = 0; i < 10; i++) begin
            txn(1, 1, 0, fw);
            chk("starve_order", {31'd0, fw}, {31'd0, i == 4 || i == 9});
        end
        if_p = 0; if_req = 0;
        // store with three wait states
        d_p = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        txn(0, 0, 3, fw);
        // timeout, then ready colliding with the timeout cycle
        d_p = 1; d_we = 0; d_addr = 32'h80;
        txn(0, 0, 100, fw);
        d_p = 1; d_we = 0; d_addr = 32'h84;
        txn(0, 0, TMO - 1, fw);
        for (int i = 0; i < 150; i++)
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), fw);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
